// File: rtl/morsecode_tx.sv
// Morse code letter transmitter.
// Accepts one letter index (0=A .. 25=Z) at a time and keys it out LSB first as
// dots (1 unit high) and dashes (3 units high). Symbols are separated by 1 low
// unit, and every letter is followed by GAP_UNITS low units.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a letter; ready=1, morse_out=0
// S_SEND | shifting the pattern out, one bit per unit
// S_GAP  | inter-letter silence, GAP_UNITS units, then done pulse
module morsecode_tx #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int GAP_UNITS   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] letter_in,
    input  logic       letter_valid,
    input  logic       abort,
    output logic       ready,
    output logic       morse_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int                TICK_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_CYCLES - 1);
    localparam logic [2:0]        GAP_LOAD  = 3'(GAP_UNITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [12:0]       shift_q, shift_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        gap_q, gap_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              morse_q, morse_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [12:0]       enc_pat;
    logic [3:0]        enc_len;
    logic              unit_end;

    // Letter encoder: tone/silence bits in send order starting at bit 0.
    always_comb begin
        enc_pat = 13'b0;
        enc_len = 4'd0;
        case (letter_in)
            5'd0:  begin enc_pat = 13'b0000000011101; enc_len = 4'd5;  end // A .-
            5'd1:  begin enc_pat = 13'b0000101010111; enc_len = 4'd9;  end // B -...
            5'd2:  begin enc_pat = 13'b0010111010111; enc_len = 4'd11; end // C -.-.
            5'd3:  begin enc_pat = 13'b0000001010111; enc_len = 4'd7;  end // D -..
            5'd4:  begin enc_pat = 13'b0000000000001; enc_len = 4'd1;  end // E .
            5'd5:  begin enc_pat = 13'b0000101110101; enc_len = 4'd9;  end // F ..-.
            5'd6:  begin enc_pat = 13'b0000101110111; enc_len = 4'd9;  end // G --.
            5'd7:  begin enc_pat = 13'b0000001010101; enc_len = 4'd7;  end // H ....
            5'd8:  begin enc_pat = 13'b0000000000101; enc_len = 4'd3;  end // I ..
            5'd9:  begin enc_pat = 13'b1110111011101; enc_len = 4'd13; end // J .---
            5'd10: begin enc_pat = 13'b0000111010111; enc_len = 4'd9;  end // K -.-
            5'd11: begin enc_pat = 13'b0000101011101; enc_len = 4'd9;  end // L .-..
            5'd12: begin enc_pat = 13'b0000001110111; enc_len = 4'd7;  end // M --
            5'd13: begin enc_pat = 13'b0000000010111; enc_len = 4'd5;  end // N -.
            5'd14: begin enc_pat = 13'b0011101110111; enc_len = 4'd11; end // O ---
            5'd15: begin enc_pat = 13'b0010111011101; enc_len = 4'd11; end // P .--.
            5'd16: begin enc_pat = 13'b1110101110111; enc_len = 4'd13; end // Q --.-
            5'd17: begin enc_pat = 13'b0000001011101; enc_len = 4'd7;  end // R .-.
            5'd18: begin enc_pat = 13'b0000000010101; enc_len = 4'd5;  end // S ...
            5'd19: begin enc_pat = 13'b0000000000111; enc_len = 4'd3;  end // T -
            5'd20: begin enc_pat = 13'b0000001110101; enc_len = 4'd7;  end // U ..-
            5'd21: begin enc_pat = 13'b0000111010101; enc_len = 4'd9;  end // V ...-
            5'd22: begin enc_pat = 13'b0000111011101; enc_len = 4'd9;  end // W .--
            5'd23: begin enc_pat = 13'b0011101010111; enc_len = 4'd11; end // X -..-
            5'd24: begin enc_pat = 13'b1110111010111; enc_len = 4'd13; end // Y -.--
            5'd25: begin enc_pat = 13'b0010101110111; enc_len = 4'd11; end // Z --..
            default: begin enc_pat = 13'b0; enc_len = 4'd0; end
        endcase
    end

    assign unit_end = (tick_q == TICK_LAST);

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        len_d   = len_q;
        gap_d   = gap_q;
        tick_d  = tick_q;
        morse_d = morse_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                morse_d = 1'b0;
                if (letter_valid) begin
                    if (letter_in < 5'd26) begin
                        state_d = S_SEND;
                        shift_d = enc_pat;
                        len_d   = enc_len;
                        tick_d  = '0;
                        morse_d = enc_pat[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    shift_d = 13'b0;
                    len_d   = 4'd0;
                    gap_d   = 3'd0;
                    tick_d  = '0;
                    morse_d = 1'b0;
                end else if (unit_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    len_d   = len_q - 4'd1;
                    if (len_q == 4'd1) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                        morse_d = 1'b0;
                    end else begin
                        morse_d = shift_q[1];
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_GAP: begin
                morse_d = 1'b0;
                if (abort) begin
                    state_d = S_IDLE;
                    shift_d = 13'b0;
                    len_d   = 4'd0;
                    gap_d   = 3'd0;
                    tick_d  = '0;
                end else if (unit_end) begin
                    tick_d = '0;
                    gap_d  = gap_q - 3'd1;
                    if (gap_q == 3'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                morse_d = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; reset wins over abort and letter_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= 13'b0;
            len_q   <= 4'd0;
            gap_q   <= 3'd0;
            tick_q  <= '0;
            morse_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            tick_q  <= tick_d;
            morse_q <= morse_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready     = ready_q;
    assign morse_out = morse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_morsecode_tx.sv
// Scoreboard bench for morsecode_tx with UNIT_CYCLES=2, GAP_UNITS=3.
// Stimulus pushes expected letter waveforms / error events and cycle-exact
// output snapshots; the monitor reconstructs each busy window and compares.
`timescale 1ns/1ps
module tb_morsecode_tx;

    localparam int UNIT     = 2;
    localparam int GAP      = 3;
    localparam int K_LETTER = 0;
    localparam int K_ERR    = 1;

    localparam int SN_RST     = 0;
    localparam int SN_LAT     = 1;
    localparam int SN_ERR1    = 2;
    localparam int SN_ERR2    = 3;
    localparam int SN_ABT     = 4;
    localparam int SN_RSTMID  = 5;
    localparam int SN_IDLEABT = 6;
    localparam int SN_DONE    = 7;
    localparam int SN_AWAVE   = 8;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       letter_valid = 1'b0;
    logic       abort        = 1'b0;
    logic [4:0] letter_in    = 5'd0;
    logic       ready, morse_out, busy, done, err;

    morsecode_tx #(.UNIT_CYCLES(UNIT), .GAP_UNITS(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .letter_in    (letter_in),
        .letter_valid (letter_valid),
        .abort        (abort),
        .ready        (ready),
        .morse_out    (morse_out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] wave;
        int          n;
        bit          done_exp;
    } rec_t;

    typedef struct {
        int         at;
        logic [4:0] expv;   // {ready, busy, morse_out, done, err}
        logic [4:0] mask;
        int         tag;
    } snap_t;

    rec_t  exp_q[$];
    snap_t snap_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    bit    end_req = 1'b0;

    string morse_tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                              "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                              "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                              "-.--", "--.."};

    function automatic string snap_name(input int tag);
        case (tag)
            SN_RST:     return "reset_state";
            SN_LAT:     return "first_tone_latency";
            SN_ERR1:    return "err_pulse";
            SN_ERR2:    return "err_cleared";
            SN_ABT:     return "abort_to_idle";
            SN_RSTMID:  return "reset_mid_letter";
            SN_IDLEABT: return "abort_in_idle";
            SN_DONE:    return "done_cycle";
            SN_AWAVE:   return "letter_a_vector";
            default:    return "snap";
        endcase
    endfunction

    // Expected keyed waveform built from the dot/dash text.
    function automatic rec_t letter_rec(input int idx);
        rec_t  r;
        string m;
        byte   c;
        int    ones;
        m          = morse_tbl[idx];
        r.kind     = K_LETTER;
        r.wave     = '0;
        r.n        = 0;
        r.done_exp = 1'b1;
        for (int i = 0; i < m.len(); i++) begin
            if (i > 0) r.n += UNIT;
            c    = m[i];
            ones = (c == "-") ? 3 * UNIT : UNIT;
            for (int k = 0; k < ones; k++) begin
                r.wave[r.n] = 1'b1;
                r.n++;
            end
        end
        r.n += GAP * UNIT;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: snapshots, busy-window records, err events, idle sanity.
    logic [63:0] obs_w = '0;
    int          obs_n = 0;
    bit          collecting = 1'b0;
    always @(negedge clk) begin
        logic [4:0] outs;
        snap_t      s;
        rec_t       r;
        outs = {ready, busy, morse_out, done, err};

        while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
            s = snap_q.pop_front();
            checks++;
            if (((outs & s.mask) !== (s.expv & s.mask)) || (s.at != cyc)) begin
                errors++;
                $display("FAIL %s cycle %0d: {ready,busy,morse,done,err}=%b required %b mask %b (due cycle %0d)",
                         snap_name(s.tag), cyc, outs, s.expv, s.mask, s.at);
            end
        end

        if (busy === 1'b1) begin
            if (!collecting) begin
                collecting = 1'b1;
                obs_n      = 0;
                obs_w      = '0;
            end
            if (obs_n < 64) obs_w[obs_n] = morse_out;
            obs_n++;
        end else begin
            if (collecting) begin
                collecting = 1'b0;
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != K_LETTER) begin
                    errors++;
                    $display("FAIL letter_record cycle %0d: unexpected letter of %0d cycles wave %h", cyc, obs_n, obs_w);
                end else begin
                    r = exp_q.pop_front();
                    if (r.n != obs_n || r.wave !== obs_w || done !== r.done_exp) begin
                        errors++;
                        $display("FAIL letter_record cycle %0d: got %0d cycles wave %h done %b, required %0d cycles wave %h done %b",
                                 cyc, obs_n, obs_w, done, r.n, r.wave, r.done_exp);
                    end
                end
            end else begin
                checks++;
                if (done !== 1'b0 || morse_out !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_quiet cycle %0d: done=%b morse_out=%b required 0 0", cyc, done, morse_out);
                end
            end
        end

        if (err === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_ERR || ready !== 1'b1 || morse_out !== 1'b0) begin
                errors++;
                $display("FAIL err_event cycle %0d: err=1 ready=%b morse_out=%b, required queued error with ready=1 morse_out=0 (queue %0d)",
                         cyc, ready, morse_out, exp_q.size());
            end else begin
                void'(exp_q.pop_front());
            end
        end

        if (end_req) begin
            checks++;
            if (exp_q.size() != 0 || snap_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: %0d records and %0d snapshots outstanding, required 0 0", exp_q.size(), snap_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic push_snap(input int k, input logic [4:0] e, input logic [4:0] m, input int tag);
        snap_t s;
        s.at   = cyc + k;
        s.expv = e;
        s.mask = m;
        s.tag  = tag;
        snap_q.push_back(s);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(ready === 1'b1 && busy === 1'b0)) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                $display("FAIL wait_idle: ready=%b busy=%b after %0d cycles, required ready=1 busy=0", ready, busy, t);
                $fatal(1, "idle timeout");
            end
        end
    endtask

    // Offer a letter this cycle (cycle 0); trunc_n>0 means the letter will be
    // cut short after trunc_n busy cycles without a done pulse.
    task automatic issue(input int idx, input bit with_abort, input int trunc_n);
        rec_t r;
        letter_valid = 1'b1;
        letter_in    = 5'(idx);
        abort        = with_abort;
        if (idx < 26) begin
            r = letter_rec(idx);
            if (trunc_n > 0) begin
                r.n        = trunc_n;
                r.wave     = r.wave & ((64'd1 << trunc_n) - 64'd1);
                r.done_exp = 1'b0;
            end
            exp_q.push_back(r);
            push_snap(1, 5'b01100, 5'b11111, SN_LAT);
        end else begin
            r.kind     = K_ERR;
            r.wave     = '0;
            r.n        = 0;
            r.done_exp = 1'b0;
            exp_q.push_back(r);
            push_snap(1, 5'b10001, 5'b11111, SN_ERR1);
            push_snap(2, 5'b10000, 5'b11111, SN_ERR2);
        end
        @(negedge clk);
        letter_valid = 1'b0;
        abort        = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        push_snap(1, 5'b10000, 5'b11111, SN_RST);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // A with hand-computed cycle vector (now at cycle 1 after issue).
        wait_idle();
        issue(0, 1'b0, 0);
        push_snap(2,  5'b01000, 5'b01100, SN_AWAVE);
        push_snap(4,  5'b01100, 5'b01100, SN_AWAVE);
        push_snap(10, 5'b01000, 5'b01100, SN_AWAVE);
        push_snap(15, 5'b01000, 5'b01100, SN_AWAVE);
        push_snap(16, 5'b10010, 5'b11111, SN_DONE);

        // E then T accepted on E's done cycle (cycle 9).
        wait_idle();
        issue(4, 1'b0, 0);
        push_snap(8, 5'b10010, 5'b11111, SN_DONE);
        repeat (8) @(negedge clk);
        issue(19, 1'b0, 0);

        // Invalid codes at both ends of the illegal range.
        wait_idle();
        issue(27, 1'b0, 0);
        repeat (2) @(negedge clk);
        issue(26, 1'b0, 0);
        repeat (2) @(negedge clk);
        issue(31, 1'b0, 0);
        repeat (2) @(negedge clk);

        // J: longest pattern, done in cycle 33.
        wait_idle();
        issue(9, 1'b0, 0);
        push_snap(32, 5'b10010, 5'b11111, SN_DONE);

        // Abort in cycle 4 of A.
        wait_idle();
        issue(0, 1'b0, 4);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        push_snap(1, 5'b10000, 5'b11111, SN_ABT);
        @(negedge clk);
        abort = 1'b0;

        // Abort during the gap of I (cycle 8).
        wait_idle();
        issue(8, 1'b0, 8);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        push_snap(1, 5'b10000, 5'b11111, SN_ABT);
        @(negedge clk);
        abort = 1'b0;

        // Reset in cycle 6 of A, then B accepted in cycle 7.
        wait_idle();
        issue(0, 1'b0, 6);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        push_snap(1, 5'b10000, 5'b11111, SN_RSTMID);
        @(negedge clk);
        reset = 1'b0;
        issue(1, 1'b0, 0);

        // Abort alone in IDLE does nothing.
        wait_idle();
        abort = 1'b1;
        push_snap(1, 5'b10000, 5'b11111, SN_IDLEABT);
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // Abort together with a valid letter in IDLE: letter is accepted.
        wait_idle();
        issue(13, 1'b1, 0);

        // Requests while sending are ignored (valid and invalid codes).
        wait_idle();
        issue(2, 1'b0, 0);
        repeat (3) @(negedge clk);
        letter_valid = 1'b1;
        letter_in    = 5'd5;
        @(negedge clk);
        letter_in    = 5'd30;
        @(negedge clk);
        letter_valid = 1'b0;

        // Whole alphabet, each accepted on the previous letter's done cycle.
        for (int i = 0; i < 26; i++) begin
            wait_idle();
            issue(i, 1'b0, 0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        end_req = 1'b1;
        repeat (10) @(negedge clk);
        $display("FAIL end_of_test: monitor did not finish");
        $fatal(1, "monitor stalled");
    end

endmodule
